// File: rtl/flag_ctx_if.sv
// Bundle between the execute stage / interrupt requester (master) and the
// flag/context controller (slave).
interface flag_ctx_if #(
  parameter int DEPTH = 4
) ();
  localparam int NW = $clog2(DEPTH + 1);

  logic          instr_valid;
  logic [4:0]    opcode;
  logic [1:0]    cmp_flags;
  logic          is_rdcsr;
  logic          csr_flag;
  logic          iret;
  logic          irq_req;
  logic          irq_ack;
  logic          stall;
  logic          gt_flag;
  logic          eq_flag;
  logic [NW-1:0] nest_lvl;
  logic          ctx_ovf;
  logic          iret_err;

  modport master (
    output instr_valid, opcode, cmp_flags, is_rdcsr, csr_flag, iret, irq_req,
    input  irq_ack, stall, gt_flag, eq_flag, nest_lvl, ctx_ovf, iret_err
  );

  modport slave (
    input  instr_valid, opcode, cmp_flags, is_rdcsr, csr_flag, iret, irq_req,
    output irq_ack, stall, gt_flag, eq_flag, nest_lvl, ctx_ovf, iret_err
  );
endinterface

// File: rtl/flag_ctx_ctrl.sv
// GT/EQ condition-flag owner with a LIFO context stack for nested interrupts.
//   state   | meaning
//   RUN     | normal commit; flags updated by CMP/RDCSR, IRET or irq may leave
//   SAVE    | push {gt,eq} at stack[nest_lvl], increment nesting
//   ACK     | one-cycle irq_ack pulse, then back to RUN
//   RESTORE | pop {gt,eq} from stack[nest_lvl-1], decrement nesting
module flag_ctx_ctrl #(
  parameter int         DEPTH   = 4,
  parameter logic [4:0] CMP_OPC = 5'b00101
) (
  input  logic        clk,
  input  logic        rst_n,
  flag_ctx_if.slave   bus
);
  localparam int            NW      = $clog2(DEPTH + 1);
  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [NW-1:0] MAX_LVL = NW'(DEPTH);

  typedef enum logic [1:0] {RUN, SAVE, ACK, RESTORE} state_t;

  state_t        state;
  logic          gt_q;
  logic          eq_q;
  logic [NW-1:0] nest_q;
  logic          irq_ack_q;
  logic          stall_q;
  logic          ctx_ovf_q;
  logic          iret_err_q;
  logic [1:0]    stack [DEPTH];

  logic          is_cmp;
  logic          is_rd;
  logic          is_iret;
  logic          iret_go;
  logic [NW-1:0] nest_dec;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;

  // Rule priority in RUN: CMP, then RDCSR, then IRET.
  always_comb begin
    is_cmp   = bus.instr_valid && (bus.opcode == CMP_OPC);
    is_rd    = bus.instr_valid && !is_cmp && bus.is_rdcsr;
    is_iret  = bus.instr_valid && !is_cmp && !bus.is_rdcsr && bus.iret;
    iret_go  = is_iret && (nest_q != '0);
    nest_dec = nest_q - NW'(1);
    push_idx = nest_q[IW-1:0];
    pop_idx  = nest_dec[IW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      nest_q     <= '0;
      irq_ack_q  <= 1'b0;
      stall_q    <= 1'b0;
      ctx_ovf_q  <= 1'b0;
      iret_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= 2'b00;
    end else begin
      case (state)
        RUN: begin
          if (is_cmp) begin
            {gt_q, eq_q} <= bus.cmp_flags;
          end else if (is_rd) begin
            gt_q <= bus.csr_flag;
            eq_q <= ~bus.csr_flag;
          end else if (is_iret && (nest_q == '0)) begin
            iret_err_q <= 1'b1;
          end
          // A returning IRET wins over a pending irq; the irq is taken after RESTORE.
          if (iret_go) begin
            state   <= RESTORE;
            stall_q <= 1'b1;
          end else if (bus.irq_req && (nest_q != MAX_LVL)) begin
            state   <= SAVE;
            stall_q <= 1'b1;
          end else if (bus.irq_req) begin
            ctx_ovf_q <= 1'b1;
          end
        end
        SAVE: begin
          stack[push_idx] <= {gt_q, eq_q};
          nest_q          <= nest_q + NW'(1);
          irq_ack_q       <= 1'b1;
          state           <= ACK;
        end
        ACK: begin
          irq_ack_q <= 1'b0;
          stall_q   <= 1'b0;
          state     <= RUN;
        end
        RESTORE: begin
          {gt_q, eq_q} <= stack[pop_idx];
          nest_q       <= nest_dec;
          stall_q      <= 1'b0;
          state        <= RUN;
        end
        default: begin
          state   <= RUN;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_ack  = irq_ack_q;
  assign bus.stall    = stall_q;
  assign bus.gt_flag  = gt_q;
  assign bus.eq_flag  = eq_q;
  assign bus.nest_lvl = nest_q;
  assign bus.ctx_ovf  = ctx_ovf_q;
  assign bus.iret_err = iret_err_q;
endmodule

// File: tb/tb_flag_ctx_ctrl.sv
// Directed bench for flag_ctx_ctrl: flag updates, nested interrupts, overflow,
// IRET underflow, IRET/irq collision and reset abort mid-save.
module tb_flag_ctx_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  flag_ctx_if #(.DEPTH(4)) bus ();

  flag_ctx_ctrl #(.DEPTH(4), .CMP_OPC(5'b00101)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
    bus.opcode      = 5'b00000;
    bus.cmp_flags   = 2'b00;
    bus.is_rdcsr    = 1'b0;
    bus.csr_flag    = 1'b0;
    bus.iret        = 1'b0;
  endtask

  task automatic do_cmp(input logic [1:0] f);
    bus.instr_valid = 1'b1;
    bus.opcode      = 5'b00101;
    bus.cmp_flags   = f;
    cyc();
    idle();
  endtask

  task automatic flags(input string tag, input logic [1:0] exp);
    chk(tag, {6'b0, bus.gt_flag, bus.eq_flag}, {6'b0, exp});
  endtask

  // irq_req rise -> SAVE -> ACK (pulse) -> RUN
  task automatic irq_take(input string tag, input logic [2:0] exp_nest);
    bus.irq_req = 1'b1;
    cyc();
    chk({tag, "_save_stall"}, {7'b0, bus.stall}, 8'd1);
    cyc();
    chk({tag, "_ack"}, {7'b0, bus.irq_ack}, 8'd1);
    chk({tag, "_nest"}, {5'b0, bus.nest_lvl}, {5'b0, exp_nest});
    bus.irq_req = 1'b0;
    cyc();
    chk({tag, "_ack_low"}, {7'b0, bus.irq_ack}, 8'd0);
    chk({tag, "_run_stall"}, {7'b0, bus.stall}, 8'd0);
  endtask

  task automatic do_iret(input string tag, input logic [1:0] exp_f, input logic [2:0] exp_nest);
    bus.instr_valid = 1'b1;
    bus.iret        = 1'b1;
    cyc();
    idle();
    chk({tag, "_rst_stall"}, {7'b0, bus.stall}, 8'd1);
    cyc();
    chk({tag, "_stall_low"}, {7'b0, bus.stall}, 8'd0);
    flags({tag, "_flags"}, exp_f);
    chk({tag, "_nest"}, {5'b0, bus.nest_lvl}, {5'b0, exp_nest});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.irq_req = 1'b0;
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    flags("reset_flags", 2'b00);
    chk("reset_nest", {5'b0, bus.nest_lvl}, 8'd0);
    chk("reset_stall", {7'b0, bus.stall}, 8'd0);
    chk("reset_ack", {7'b0, bus.irq_ack}, 8'd0);

    // CMP and non-CMP opcode
    do_cmp(2'b10);
    flags("cmp_10", 2'b10);
    bus.instr_valid = 1'b1;
    bus.opcode      = 5'b00100;
    bus.cmp_flags   = 2'b01;
    cyc();
    idle();
    flags("noncmp_hold", 2'b10);

    // RDCSR, then CMP beating RDCSR
    bus.instr_valid = 1'b1;
    bus.is_rdcsr    = 1'b1;
    bus.csr_flag    = 1'b0;
    cyc();
    idle();
    flags("rdcsr_0", 2'b01);
    bus.instr_valid = 1'b1;
    bus.is_rdcsr    = 1'b1;
    bus.csr_flag    = 1'b1;
    cyc();
    idle();
    flags("rdcsr_1", 2'b10);
    bus.instr_valid = 1'b1;
    bus.is_rdcsr    = 1'b1;
    bus.csr_flag    = 1'b1;
    bus.opcode      = 5'b00101;
    bus.cmp_flags   = 2'b01;
    cyc();
    idle();
    flags("cmp_beats_rdcsr", 2'b01);

    // Nested interrupts with LIFO restore
    do_cmp(2'b10);
    irq_take("irq1", 3'd1);
    flags("irq1_flags_kept", 2'b10);
    do_cmp(2'b01);
    irq_take("irq2", 3'd2);
    do_cmp(2'b11);
    do_iret("iret2", 2'b01, 3'd1);
    do_iret("iret1", 2'b10, 3'd0);

    // Overflow at full depth
    irq_take("ovf_a", 3'd1);
    irq_take("ovf_b", 3'd2);
    irq_take("ovf_c", 3'd3);
    irq_take("ovf_d", 3'd4);
    bus.irq_req = 1'b1;
    cyc();
    chk("ovf_no_stall", {7'b0, bus.stall}, 8'd0);
    chk("ovf_sticky", {7'b0, bus.ctx_ovf}, 8'd1);
    cyc();
    chk("ovf_no_ack", {7'b0, bus.irq_ack}, 8'd0);
    chk("ovf_nest", {5'b0, bus.nest_lvl}, 8'd4);
    bus.irq_req = 1'b0;
    do_iret("unw4", 2'b10, 3'd3);
    do_iret("unw3", 2'b10, 3'd2);
    do_iret("unw2", 2'b10, 3'd1);
    do_iret("unw1", 2'b10, 3'd0);

    // IRET at nesting 0
    do_cmp(2'b01);
    chk("iret_err_pre", {7'b0, bus.iret_err}, 8'd0);
    bus.instr_valid = 1'b1;
    bus.iret        = 1'b1;
    cyc();
    idle();
    chk("iret_err_set", {7'b0, bus.iret_err}, 8'd1);
    chk("iret_err_no_stall", {7'b0, bus.stall}, 8'd0);
    flags("iret_err_flags", 2'b01);
    chk("iret_err_nest", {5'b0, bus.nest_lvl}, 8'd0);
    chk("ovf_still_sticky", {7'b0, bus.ctx_ovf}, 8'd1);

    // IRET and irq_req together at nesting 1
    irq_take("col_in", 3'd1);
    do_cmp(2'b11);
    bus.instr_valid = 1'b1;
    bus.iret        = 1'b1;
    bus.irq_req     = 1'b1;
    cyc();
    idle();
    chk("col_restore_stall", {7'b0, bus.stall}, 8'd1);
    chk("col_no_ack", {7'b0, bus.irq_ack}, 8'd0);
    cyc();
    flags("col_restored", 2'b01);
    chk("col_nest0", {5'b0, bus.nest_lvl}, 8'd0);
    cyc();
    chk("col_save_stall", {7'b0, bus.stall}, 8'd1);
    cyc();
    chk("col_ack", {7'b0, bus.irq_ack}, 8'd1);
    chk("col_nest1", {5'b0, bus.nest_lvl}, 8'd1);
    bus.irq_req = 1'b0;
    cyc();
    do_cmp(2'b10);
    do_iret("col_out", 2'b01, 3'd0);

    // Reset asserted mid-SAVE
    do_cmp(2'b11);
    bus.irq_req = 1'b1;
    cyc();
    chk("t1_in_save", {7'b0, bus.stall}, 8'd1);
    rst_n = 1'b0;
    #2;
    chk("t1_async_stall", {7'b0, bus.stall}, 8'd0);
    flags("t1_async_flags", 2'b00);
    chk("t1_async_sticky", {6'b0, bus.ctx_ovf, bus.iret_err}, 8'd0);
    bus.irq_req = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("t1_run_stall", {7'b0, bus.stall}, 8'd0);
    chk("t1_run_ack", {7'b0, bus.irq_ack}, 8'd0);
    chk("t1_nest", {5'b0, bus.nest_lvl}, 8'd0);
    flags("t1_flags", 2'b00);
    do_cmp(2'b10);
    flags("t1_cmp_after", 2'b10);
    // The aborted SAVE must not have left an entry behind.
    irq_take("t1_irq", 3'd1);
    do_cmp(2'b00);
    do_iret("t1_iret", 2'b10, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
